// File: rtl/des_input_stage.sv
// Byte-serial front end for the DES core: assembles 8-byte data/key/IV groups and hands blocks over valid/ready.
// Optional CBC chaining is compiled in when DES_INPUT_CBC_EN is defined; the default build is ECB.
module des_input_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic [1:0]  s_sel,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_block,
  output logic [55:0] m_key,
  input  logic        fb_valid,
  input  logic [63:0] fb_cipher,
  output logic        key_valid,
  output logic        parity_err,
  output logic        nokey_err
);

  localparam int unsigned BLK_W   = 64;
  localparam int unsigned KEY_W   = 56;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned NBYTES  = BLK_W / BYTE_W;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  localparam logic [SEL_W-1:0] SEL_KEY = 2'b01;
  localparam logic [SEL_W-1:0] SEL_IV  = 2'b10;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  grp;
  logic [BLK_W-1:0]  asm_q;

  logic              accept;
  logic              last;
  logic [SEL_W-1:0]  grp_cur;
  logic              is_key;
  logic              is_iv;
  logic              is_data;
  logic [BLK_W-1:0]  full;
  logic [KEY_W-1:0]  key_strip;
  logic              key_par_bad;
  logic [BLK_W-1:0]  blk_c;
  logic              unused_bits;

  assign m_valid = (state == HOLD);
  assign s_ready = ~m_valid;

  // Group decode, assembled value and key parity strip/check for the byte being accepted
  always_comb begin
    accept      = s_valid & s_ready;
    last        = accept && (cnt == CNT_W'(NBYTES - 1));
    grp_cur     = (cnt == '0) ? s_sel : grp;
    is_key      = (grp_cur == SEL_KEY);
    is_iv       = (grp_cur == SEL_IV);
    is_data     = !is_key && !is_iv;
    full        = {asm_q[BLK_W-BYTE_W-1:0], s_data};
    key_strip   = '0;
    key_par_bad = 1'b0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      key_strip[KEY_W-1-7*i -: 7] = full[BLK_W-1-BYTE_W*i -: 7];
      key_par_bad = key_par_bad | ~(^full[BLK_W-1-BYTE_W*i -: BYTE_W]);
    end
  end

`ifdef DES_INPUT_CBC_EN
  logic [BLK_W-1:0] chain;

  assign blk_c = full ^ chain;

  // IV completion takes priority over a same-cycle ciphertext feedback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (last && is_iv) begin
      chain <= full;
    end else if (fb_valid) begin
      chain <= fb_cipher;
    end
  end

  assign unused_bits = ^{asm_q[BLK_W-1:BLK_W-BYTE_W]};
`else
  assign blk_c       = full;
  assign unused_bits = ^{asm_q[BLK_W-1:BLK_W-BYTE_W], fb_valid, fb_cipher, is_iv};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (last && is_data && key_valid) state_nxt = HOLD;
      HOLD:    if (m_ready)                      state_nxt = COLLECT;
      default:                                   state_nxt = COLLECT;
    endcase
  end

  // Byte assembly, key load and block capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      grp        <= '0;
      asm_q      <= '0;
      m_block    <= '0;
      m_key      <= '0;
      key_valid  <= 1'b0;
      parity_err <= 1'b0;
      nokey_err  <= 1'b0;
    end else begin
      if (accept) begin
        cnt   <= cnt + CNT_W'(1);
        asm_q <= full;
        if (cnt == '0) grp <= s_sel;
      end
      if (last && is_key) begin
        m_key      <= key_strip;
        key_valid  <= 1'b1;
        parity_err <= key_par_bad;
      end
      if (last && is_data) begin
        if (key_valid) m_block   <= blk_c;
        else           nokey_err <= 1'b1;
      end
    end
  end

endmodule
